// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: the ROM read port, the EX redirect inputs and the
// valid/ready handshake towards ID.
interface ifetch_if;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic [31:0] irom_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [2:0]  id_ext_op;

  modport master (
    output irom_req, irom_addr,
    input  irom_rdata,
    input  redir_valid, redir_pc,
    input  id_ready,
    output id_valid, id_inst, id_pc, id_pc4, id_ext_op
  );

  modport slave (
    input  irom_req, irom_addr,
    output irom_rdata,
    output redir_valid, redir_pc,
    output id_ready,
    input  id_valid, id_inst, id_pc, id_pc4, id_ext_op
  );
endinterface

// File: rtl/ifetch_queue.sv
// miniRV instruction fetch: owns the PC, reads the 1-cycle ROM and queues
// {pc, inst, ext_op} for ID. IFETCH_PERF_CNT_EN adds fetch/flush counters.
//
// state | meaning
// BOOT  | one idle cycle after reset, no ROM read
// RUN   | normal fetch, redirect and queue handling
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] EXT_NONE = 3'd0;
  localparam logic [2:0] EXT_I    = 3'd1;
  localparam logic [2:0] EXT_S    = 3'd2;
  localparam logic [2:0] EXT_B    = 3'd3;
  localparam logic [2:0] EXT_U    = 3'd4;
  localparam logic [2:0] EXT_J    = 3'd5;

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [31:0]   q_inst [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [2:0]    q_ext  [QDEPTH];

  logic          deq;
  logic          enq;
  logic          issue;
  logic [CW-1:0] occ;

  function automatic logic [2:0] pre_decode(input logic [6:0] opc);
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: pre_decode = EXT_I;
      7'b0100011:                         pre_decode = EXT_S;
      7'b1100011:                         pre_decode = EXT_B;
      7'b0110111, 7'b0010111:             pre_decode = EXT_U;
      7'b1101111:                         pre_decode = EXT_J;
      default:                            pre_decode = EXT_NONE;
    endcase
  endfunction

  // A redirect cycle blocks both the handshake and the ROM read.
  always_comb begin
    bus.id_valid = (count != '0) && !bus.redir_valid;
    deq          = bus.id_valid && bus.id_ready;
    enq          = inflight && !bus.redir_valid;
    occ          = count + CW'(inflight) - CW'(deq);
    issue        = (state == ST_RUN) && !bus.redir_valid && (occ < CW'(QDEPTH));
  end

  assign bus.irom_req  = issue;
  assign bus.irom_addr = pc;
  assign bus.id_inst   = q_inst[head];
  assign bus.id_pc     = q_pc[head];
  assign bus.id_pc4    = q_pc[head] + 32'd4;
  assign bus.id_ext_op = q_ext[head];

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (bus.redir_valid) begin
      state    <= ST_RUN;
      pc       <= bus.redir_pc;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= ST_RUN;
      inflight <= issue;
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // The issue rule guarantees the tail slot is free whenever data returns.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && enq) begin
      q_inst[tail] <= bus.irom_rdata;
      q_pc[tail]   <= req_pc;
      q_ext[tail]  <= pre_decode(bus.irom_rdata[6:0]);
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, perf_flushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (deq && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (bus.redir_valid)
        perf_flushed <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: boot latency, streaming, stall, redirects,
// ext_op pre-decode, mid-stream reset and PC wrap.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ifetch_if bus();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
  ifetch_queue dut (.cpu_clk(clk), .cpu_rst(rst), .bus(bus),
                    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed));
`else
  ifetch_queue dut (.cpu_clk(clk), .cpu_rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h40:  rom = 32'h00C0_00EF;
      32'h44:  rom = 32'h0020_8033;
      32'h48:  rom = 32'hFE20_9EE3;
      32'h4C:  rom = 32'h0000_0013;
      default: rom = a >> 2;
    endcase
  endfunction

  // Unrequested cycles return a jal-looking junk word so stray writes show up.
  always @(posedge clk)
    bus.irom_rdata <= bus.irom_req ? rom(bus.irom_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst             = r;
    bus.id_ready    = rdy;
    bus.redir_valid = rv;
    bus.redir_pc    = rpc;
    #2;
  endtask

  initial begin
    rst             = 1'b1;
    bus.id_ready    = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // c1: BOOT
    step(0, 1, 0, 0);
    chk("rst_req", 32'(bus.irom_req), 0);
    chk("rst_valid", 32'(bus.id_valid), 0);
    chk("rst_addr", bus.irom_addr, 32'h0);
    // c2, c3
    step(0, 1, 0, 0);
    chk("c2_req", 32'(bus.irom_req), 1);
    chk("c2_addr", bus.irom_addr, 32'h0);
    step(0, 1, 0, 0);
    chk("c3_valid", 32'(bus.id_valid), 0);
    chk("c3_addr", bus.irom_addr, 32'h4);
    // c4..c6 streaming
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("str_valid", 32'(bus.id_valid), 1);
      chk("str_pc", bus.id_pc, 32'(4 * i));
      chk("str_pc4", bus.id_pc4, 32'(4 * i + 4));
      chk("str_inst", bus.id_inst, 32'(i));
      chk("str_req", 32'(bus.irom_req), 1);
    end
    // c7..c11 stall
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("stl_valid", 32'(bus.id_valid), 1);
      chk("stl_pc", bus.id_pc, 32'h0C);
      chk("stl_req", 32'(bus.irom_req), 0);
    end
    // c12..c15 release
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("rel_valid", 32'(bus.id_valid), 1);
      chk("rel_pc", bus.id_pc, 32'(32'h0C + 4 * i));
      chk("rel_inst", bus.id_inst, 32'(3 + i));
    end
    // c16 redirect with a word queued and one in flight
    step(0, 1, 1, 32'h100);
    chk("rd_valid", 32'(bus.id_valid), 0);
    chk("rd_req", 32'(bus.irom_req), 0);
    step(0, 1, 0, 0);
    chk("rd1_req", 32'(bus.irom_req), 1);
    chk("rd1_addr", bus.irom_addr, 32'h100);
    chk("rd1_valid", 32'(bus.id_valid), 0);
    step(0, 1, 0, 0);
    chk("rd2_valid", 32'(bus.id_valid), 0);
    chk("rd2_addr", bus.irom_addr, 32'h104);
    step(0, 1, 0, 0);
    chk("rd3_valid", 32'(bus.id_valid), 1);
    chk("rd3_pc", bus.id_pc, 32'h100);
    chk("rd3_inst", bus.id_inst, 32'h40);
    step(0, 1, 0, 0);
    chk("rd4_pc", bus.id_pc, 32'h104);
    // fill the queue, then back-to-back redirects
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("full_pc", bus.id_pc, 32'h108);
    chk("full_req", 32'(bus.irom_req), 0);
    step(0, 0, 1, 32'h200);
    chk("bb1_valid", 32'(bus.id_valid), 0);
    step(0, 0, 1, 32'h40);
    chk("bb2_valid", 32'(bus.id_valid), 0);
    chk("bb2_req", 32'(bus.irom_req), 0);
    step(0, 1, 0, 0);
    chk("bb_addr", bus.irom_addr, 32'h40);
    chk("bb_req", 32'(bus.irom_req), 1);
    step(0, 1, 0, 0);
    chk("bb_valid", 32'(bus.id_valid), 0);
    // ext_op pre-decode
    step(0, 1, 0, 0);
    chk("jal_pc", bus.id_pc, 32'h40);
    chk("jal_inst", bus.id_inst, 32'h00C0_00EF);
    chk("jal_ext", 32'(bus.id_ext_op), 5);
    step(0, 1, 0, 0);
    chk("add_ext", 32'(bus.id_ext_op), 0);
    step(0, 1, 0, 0);
    chk("bne_ext", 32'(bus.id_ext_op), 3);
    step(0, 1, 0, 0);
    chk("addi_ext", 32'(bus.id_ext_op), 1);
    // mid-stream reset with a read in flight
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("mr_valid", 32'(bus.id_valid), 0);
    chk("mr_req", 32'(bus.irom_req), 0);
    chk("mr_addr", bus.irom_addr, 32'h0);
    step(0, 1, 0, 0);
    chk("mr_req2", 32'(bus.irom_req), 1);
    chk("mr_addr2", bus.irom_addr, 32'h0);
    step(0, 1, 0, 0);
    chk("mr_valid3", 32'(bus.id_valid), 0);
    step(0, 1, 0, 0);
    chk("mr_valid4", 32'(bus.id_valid), 1);
    chk("mr_pc", bus.id_pc, 32'h0);
    // PC wrap
    step(0, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wr_addr", bus.irom_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wr_addr2", bus.irom_addr, 32'h0);
    step(0, 1, 0, 0);
    chk("wr_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.id_pc4, 32'h0);
    chk("wr_inst", bus.id_inst, 32'h3FFF_FFFF);
    step(0, 1, 0, 0);
    chk("wr_pc_next", bus.id_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
